vram_scanout: RTL and testbench

- Display-side reader of the processor's VRAM.
- Generates VGA raster timing and a sequential `gpu_address` stream into the VRAM read port, then converts returned `vram_out` grayscale bytes into RGB pixels with aligned sync.
- Sits between `mide_cpu`'s VRAM read port and the board VGA DAC; it replaces the bench-driven address counter.

---
 rtl/vram_scanout_if.sv | 37 +++
 rtl/vram_scanout.sv | 126 ++++++++++++
 tb/tb_vram_scanout.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vram_scanout_if.sv
// Bus between the scanout engine, the VRAM read port and the VGA DAC.
// The master drives addresses and pixels; the slave supplies read data and consumes video.
interface vram_scanout_if;
    logic [31:0] gpu_address;
    logic [7:0]  vram_out;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        frame_start;

    modport master (
        output gpu_address,
        input  vram_out,
        output vga_r,
        output vga_g,
        output vga_b,
        output hsync,
        output vsync,
        output blank_n,
        output frame_start
    );

    modport slave (
        input  gpu_address,
        output vram_out,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  hsync,
        input  vsync,
        input  blank_n,
        input  frame_start
    );
endinterface

// File: rtl/vram_scanout.sv
// VGA raster generator that streams a grayscale image out of VRAM.
// A running address pointer walks the image; one registered output stage aligns RGB with sync/blank.
module vram_scanout #(
    parameter int          CLK_DIV   = 2,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          IMG_W     = 256,
    parameter int          IMG_H     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input logic             clk,
    input logic             reset,
    vram_scanout_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_W_C  = HW'(IMG_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] IMG_H_C  = VW'(IMG_H);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    pix_q, pix_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_n_q, blank_n_d;
    logic          frame_start_q, frame_start_d;

    logic tick, h_wrap, v_wrap, frame_wrap;
    logic active, in_img, hs, vs;

    // Stage 0: decode of the current raster position.
    always_comb begin
        tick       = (div_cnt_q == DIV_LAST);
        h_wrap     = (h_cnt_q == H_LAST);
        v_wrap     = (v_cnt_q == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        active     = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        in_img     = (h_cnt_q < IMG_W_C) && (v_cnt_q < IMG_H_C);
        hs         = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
        vs         = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));
    end

    always_comb begin
        div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        addr_d        = addr_q;
        pix_d         = pix_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_n_d     = blank_n_q;
        frame_start_d = tick && frame_wrap;
        if (tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end
            // Image rows are contiguous, so a pointer that only advances inside
            // the window lands on BASE_ADDR + y*IMG_W at the start of each row.
            if (frame_wrap) begin
                addr_d = BASE_ADDR;
            end else if (in_img) begin
                addr_d = addr_q + 32'd1;
            end
            // Address has been stable for CLK_DIV-1 clk, so vram_out belongs to this pixel.
            pix_d     = in_img ? bus.vram_out : 8'h00;
            hs_d      = hs;
            vs_d      = vs;
            blank_n_d = active;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            addr_q        <= BASE_ADDR;
            pix_q         <= 8'h00;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            addr_q        <= addr_d;
            pix_q         <= pix_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.gpu_address = addr_q;
    assign bus.vga_r       = pix_q;
    assign bus.vga_g       = pix_q;
    assign bus.vga_b       = pix_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.blank_n     = blank_n_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout on a small raster (15x10 pixels, 4x4 image at 0x1000).
// Stimulus queues per-pixel expectations; a negedge monitor pops one per pixel tick.
module tb_vram_scanout;
    localparam int          CD   = 2;
    localparam int          HA   = 8;
    localparam int          HFP  = 2;
    localparam int          HS   = 3;
    localparam int          HBP  = 2;
    localparam int          VA   = 6;
    localparam int          VFP  = 1;
    localparam int          VS   = 2;
    localparam int          VBP  = 1;
    localparam int          IW   = 4;
    localparam int          IH   = 4;
    localparam logic [31:0] BASE = 32'h1000;
    localparam int          HT   = HA + HFP + HS + HBP;
    localparam int          VT   = VA + VFP + VS + VBP;
    localparam int          FRAME = HT * VT;

    typedef struct {
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic [31:0] addr;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    rec_t exp_q[$];
    rec_t r;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    vram_scanout_if bus();

    vram_scanout #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // VRAM model: data = addr[7:0], one clk of latency.
    always @(posedge clk) bus.vram_out <= bus.gpu_address[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address held after the raster reaches position q (raster order from (0,0)).
    function automatic logic [31:0] addr_at(input int q);
        int x, y, off;
        x = q % HT;
        y = q / HT;
        if (y < IH) off = y * IW + ((x < IW) ? x : IW);
        else        off = IW * IH;
        return BASE + 32'(off);
    endfunction

    // Expected output after the n-th pixel tick (n >= 1): shows pixel n-1.
    function automatic rec_t exp_rec(input int n);
        rec_t e;
        int p, x, y;
        logic [31:0] a;
        p = (n - 1) % FRAME;
        x = p % HT;
        y = p / HT;
        a = addr_at(p);
        e.rgb   = (x < IW && y < IH) ? a[7:0] : 8'h00;
        e.hs    = !(x >= HA + HFP && x < HA + HFP + HS);
        e.vs    = !(y >= VA + VFP && y < VA + VFP + VS);
        e.blank = (x < HA) && (y < VA);
        e.fs    = ((n % FRAME) == 0);
        e.addr  = addr_at(n % FRAME);
        return e;
    endfunction

    task automatic push_frames(input int nf);
        for (int n = 1; n <= nf * FRAME; n++) exp_q.push_back(exp_rec(n));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_addr"},  bus.gpu_address, BASE);
        check({tag, "_r"},     32'(bus.vga_r), 32'h0);
        check({tag, "_g"},     32'(bus.vga_g), 32'h0);
        check({tag, "_b"},     32'(bus.vga_b), 32'h0);
        check({tag, "_hsync"}, 32'(bus.hsync), 32'h1);
        check({tag, "_vsync"}, 32'(bus.vsync), 32'h1);
        check({tag, "_blank"}, 32'(bus.blank_n), 32'h0);
        check({tag, "_fs"},    32'(bus.frame_start), 32'h0);
    endtask

    // Clk edges since reset release; outputs update on every CD-th edge.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset && !done && cyc > 0) begin
            if (cyc % CD != 0) begin
                check("fs_between_ticks", 32'(bus.frame_start), 32'h0);
            end else if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL queue_underrun: no expectation for tick at clk %0d", cyc);
            end else begin
                r = exp_q.pop_front();
                check("vga_r",       32'(bus.vga_r), 32'(r.rgb));
                check("vga_g",       32'(bus.vga_g), 32'(r.rgb));
                check("vga_b",       32'(bus.vga_b), 32'(r.rgb));
                check("hsync",       32'(bus.hsync), 32'(r.hs));
                check("vsync",       32'(bus.vsync), 32'(r.vs));
                check("blank_n",     32'(bus.blank_n), 32'(r.blank));
                check("frame_start", 32'(bus.frame_start), 32'(r.fs));
                check("gpu_address", bus.gpu_address, r.addr);
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        push_frames(3);
        reset = 1'b0;

        // Reset mid-frame, inside the image window of the third frame.
        repeat (697) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("midreset");
        exp_q.delete();
        push_frames(2);
        reset = 1'b0;

        repeat (2 * FRAME * CD) @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
